// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal word FIFO. Frames are start, DATA_BITS LSB first,
// an optional parity bit and STOP_BITS stop bits; queued words go out back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_dv,
    input  logic [DATA_BITS-1:0]          tx_byte,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_done,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   serial_q, serial_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push, pop, bit_end, fifo_empty, done;
    logic [DATA_BITS-1:0]   head;

    assign tx_ready   = (count_q != FULL_CNT);
    assign push       = tx_dv && tx_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign bit_end    = (clk_cnt_q == CLK_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        serial_d  = serial_q;
        pop       = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                serial_d  = 1'b1;
                pop       = !fifo_empty;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                    serial_d  = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        pop     = !fifo_empty;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Loading a frame is shared by IDLE and the final stop cycle, so chained frames get no gap.
        if (pop) begin
            state_d   = S_START;
            clk_cnt_d = '0;
            shift_d   = head;
            par_d     = (PARITY == 2) ? ~^head : ^head;
            serial_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            serial_q  <= serial_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_byte;
    end

    assign tx_serial  = serial_q;
    assign tx_done    = done;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_count = count_q;

endmodule
